// File: rtl/rs_pkg.sv
// Shared constants, FSM state encoding and error-entry payload for the RS(204,188)
// output correction stage.
package rs_pkg;

    localparam int unsigned N  = 204;
    localparam int unsigned K  = 188;
    localparam int unsigned T  = 8;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;
    localparam int unsigned PW = $clog2(T + 1);
    localparam int unsigned IW = $clog2(T);

    localparam logic [AW-1:0] ADDR_FIRST     = AW'(N - 1);
    localparam logic [AW-1:0] ADDR_LAST_DATA = AW'(N - K);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [AW-1:0] loc;
        logic [DW-1:0] val;
    } err_entry_t;

endpackage

// File: rtl/rs_output_correction_if.sv
// Error-entry bus from the Forney stage into the output correction stage.
interface rs_output_correction_if;
    import rs_pkg::*;

    logic          err_ready;
    logic          err_we;
    logic [AW-1:0] err_loc;
    logic [DW-1:0] err_val;
    logic          err_done;
    logic          decode_fail;

    modport master (
        input  err_ready,
        output err_we, err_loc, err_val, err_done, decode_fail
    );

    modport slave (
        output err_ready,
        input  err_we, err_loc, err_val, err_done, decode_fail
    );

endinterface

// File: rtl/rs_err_table.sv
// T-entry error table: stores location/value pairs for one block and returns the
// XOR of all values whose location matches the probe address.
module rs_err_table
    import rs_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          we,
    input  err_entry_t    wr_entry,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] err_mask,
    output logic          overflow
);

    err_entry_t      entry_q [T];
    logic [T-1:0]    valid_q;
    logic [PW-1:0]   wr_ptr_q;

    // Slot fill; writes beyond T entries only raise the overflow flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < int'(T); i++) begin
                entry_q[i] <= '0;
            end
        end else if (clear) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            overflow <= 1'b0;
        end else if (we) begin
            if (wr_ptr_q == PW'(T)) begin
                overflow <= 1'b1;
            end else begin
                entry_q[wr_ptr_q[IW-1:0]] <= wr_entry;
                valid_q[wr_ptr_q[IW-1:0]] <= 1'b1;
                wr_ptr_q                  <= wr_ptr_q + PW'(1);
            end
        end
    end

    // Parallel match; parity or out-of-range locations never contribute
    always_comb begin
        err_mask = '0;
        for (int i = 0; i < int'(T); i++) begin
            if (valid_q[i] && (entry_q[i].loc == addr) &&
                (entry_q[i].loc >= ADDR_LAST_DATA) && (entry_q[i].loc <= ADDR_FIRST)) begin
                err_mask = err_mask ^ entry_q[i].val;
            end
        end
    end

endmodule

// File: rtl/rs_output_correction.sv
// Final RS(204,188) stage: reads a buffered block back from the input memories,
// applies the Forney corrections and streams the 188 data bytes.
module rs_output_correction
    import rs_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    rs_output_correction_if.slave  err,
    output logic [AW-1:0]          R_Add,
    output logic                   RE,
    input  logic [DW-1:0]          Read_byte,
    output logic [DW-1:0]          out_byte,
    output logic                   out_valid,
    output logic                   out_sof,
    output logic                   out_eof,
    output logic                   out_fail,
    output logic                   busy
);

    state_t        state_q, state_n;
    logic [AW-1:0] r_add_n;
    logic          re_n;
    logic          drain_q, drain_n;
    logic          fail_q, fail_n;
    logic          clear_c;
    logic          tbl_we_c;
    err_entry_t    wr_entry_c;
    logic [DW-1:0] err_mask;
    logic          overflow;
    logic          blk_fail_c;
    logic          rd_vld_q;
    logic [AW-1:0] addr_q;

    assign tbl_we_c   = err.err_we && (state_q == IDLE);
    assign wr_entry_c = '{loc: err.err_loc, val: err.err_val};
    assign clear_c    = (state_q == DRAIN) && (state_n == IDLE);
    assign blk_fail_c = fail_q || overflow;

    rs_err_table u_err_table (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear_c),
        .we       (tbl_we_c),
        .wr_entry (wr_entry_c),
        .addr     (addr_q),
        .err_mask (err_mask),
        .overflow (overflow)
    );

    // Control state and registered control outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            R_Add         <= '0;
            RE            <= 1'b1;
            drain_q       <= 1'b0;
            fail_q        <= 1'b0;
            busy          <= 1'b0;
            err.err_ready <= 1'b1;
        end else begin
            state_q       <= state_n;
            R_Add         <= r_add_n;
            RE            <= re_n;
            drain_q       <= drain_n;
            fail_q        <= fail_n;
            busy          <= (state_n != IDLE);
            err.err_ready <= (state_n == IDLE);
        end
    end

    // Next-state: sweep 203..16 once, drain the two pipeline stages, swap banks
    always_comb begin
        state_n = state_q;
        r_add_n = R_Add;
        re_n    = RE;
        drain_n = drain_q;
        fail_n  = fail_q;
        case (state_q)
            IDLE: begin
                if (err.err_done) begin
                    state_n = READ;
                    r_add_n = ADDR_FIRST;
                    fail_n  = err.decode_fail;
                end
            end
            READ: begin
                if (R_Add == ADDR_LAST_DATA) begin
                    state_n = DRAIN;
                    drain_n = 1'b0;
                end else begin
                    r_add_n = R_Add - AW'(1);
                end
            end
            DRAIN: begin
                if (drain_q) begin
                    state_n = IDLE;
                    re_n    = ~RE;
                end else begin
                    drain_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Address delayed one cycle to line up with Read_byte, then correct and register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_vld_q  <= 1'b0;
            addr_q    <= '0;
            out_byte  <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            out_fail  <= 1'b0;
        end else begin
            rd_vld_q  <= (state_q == READ);
            addr_q    <= R_Add;
            out_valid <= rd_vld_q;
            out_sof   <= rd_vld_q && (addr_q == ADDR_FIRST);
            out_eof   <= rd_vld_q && (addr_q == ADDR_LAST_DATA);
            out_fail  <= rd_vld_q && blk_fail_c;
            out_byte  <= rd_vld_q ? (Read_byte ^ (blk_fail_c ? {DW{1'b0}} : err_mask))
                                  : {DW{1'b0}};
        end
    end

endmodule

// File: tb/tb_rs_output_correction.sv
// Directed plus randomized bench for rs_output_correction with a per-block
// reference model of the corrected output stream.
module tb_rs_output_correction;
    import rs_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] R_Add;
    logic       RE;
    logic [7:0] Read_byte = 8'h00;
    logic [7:0] out_byte;
    logic       out_valid, out_sof, out_eof, out_fail, busy;

    rs_output_correction_if eb();

    rs_output_correction dut (
        .clk       (clk),
        .reset     (reset),
        .err       (eb),
        .R_Add     (R_Add),
        .RE        (RE),
        .Read_byte (Read_byte),
        .out_byte  (out_byte),
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .out_fail  (out_fail),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Two input memory banks with one cycle read latency
    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    always @(posedge clk) Read_byte <= RE ? mem0[R_Add] : mem1[R_Add];

    int n_cmp = 0;
    int n_err = 0;
    bit exp_bank = 1'b1;
    logic [7:0] e_loc [$];
    logic [7:0] e_val [$];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_inputs;
        eb.err_we      = 1'b0;
        eb.err_done    = 1'b0;
        eb.decode_fail = 1'b0;
        eb.err_loc     = 8'h00;
        eb.err_val     = 8'h00;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_R_Add"},     32'(R_Add),         32'd0);
        chk({pfx, "_RE"},        32'(RE),            32'd1);
        chk({pfx, "_out_byte"},  32'(out_byte),      32'd0);
        chk({pfx, "_out_valid"}, 32'(out_valid),     32'd0);
        chk({pfx, "_out_sof"},   32'(out_sof),       32'd0);
        chk({pfx, "_out_eof"},   32'(out_eof),       32'd0);
        chk({pfx, "_out_fail"},  32'(out_fail),      32'd0);
        chk({pfx, "_busy"},      32'(busy),          32'd0);
        chk({pfx, "_err_ready"}, 32'(eb.err_ready),  32'd1);
    endtask

    task automatic fill_addr;
        for (int a = 0; a < 256; a++) begin
            mem0[a] = 8'(a);
            mem1[a] = 8'(a);
        end
    endtask

    task automatic fill_rand;
        for (int a = 0; a < 256; a++) begin
            mem0[a] = 8'($urandom);
            mem1[a] = 8'($urandom);
        end
    endtask

    // Sends the queued errors, closes the block and checks the whole readout
    task automatic run_block(input string name, input bit same_cycle, input bit dfail, input int abort_at);
        logic [7:0] exp_b [K];
        bit         exp_f;
        int         n;
        int         a;
        n     = e_loc.size();
        exp_f = dfail || (n > int'(T));
        for (int i = 0; i < int'(K); i++) begin
            a = 203 - i;
            exp_b[i] = exp_bank ? mem0[a] : mem1[a];
            if (!exp_f) begin
                for (int j = 0; j < n; j++) begin
                    if (e_loc[j] == 8'(a)) exp_b[i] = exp_b[i] ^ e_val[j];
                end
            end
        end

        chk({name, "_ready_idle"}, 32'(eb.err_ready), 32'd1);
        for (int j = 0; j < n; j++) begin
            eb.err_we  = 1'b1;
            eb.err_loc = e_loc[j];
            eb.err_val = e_val[j];
            if (same_cycle && j == n - 1) begin
                eb.err_done    = 1'b1;
                eb.decode_fail = dfail;
            end
            tick();
        end
        if (!(same_cycle && n > 0)) begin
            eb.err_we      = 1'b0;
            eb.err_done    = 1'b1;
            eb.decode_fail = dfail;
            tick();
        end
        clr_inputs();

        chk({name, "_R_Add_first"}, 32'(R_Add),        32'd203);
        chk({name, "_busy_t1"},     32'(busy),         32'd1);
        chk({name, "_ready_t1"},    32'(eb.err_ready), 32'd0);
        chk({name, "_RE"},          32'(RE),           32'(exp_bank));
        tick();
        chk({name, "_valid_t2"},    32'(out_valid),    32'd0);
        tick();

        for (int i = 0; i < int'(K); i++) begin
            if (i == abort_at) begin
                clr_inputs();
                reset = 1'b0;
                #1;
                chk_reset_vals({name, "_midrst"});
                tick();
                chk({name, "_midrst_valid"}, 32'(out_valid), 32'd0);
                reset = 1'b1;
                tick();
                tick();
                chk({name, "_postrst_valid"}, 32'(out_valid), 32'd0);
                exp_bank = 1'b1;
                return;
            end
            chk($sformatf("%s_valid%0d", name, i), 32'(out_valid), 32'd1);
            chk($sformatf("%s_byte%0d", name, i),  32'(out_byte),  32'(exp_b[i]));
            chk($sformatf("%s_sof%0d", name, i),   32'(out_sof),   32'(i == 0));
            chk($sformatf("%s_eof%0d", name, i),   32'(out_eof),   32'(i == int'(K) - 1));
            chk($sformatf("%s_fail%0d", name, i),  32'(out_fail),  32'(exp_f));
            if (i < 186) begin
                eb.err_we      = 1'($urandom_range(0, 1));
                eb.err_done    = ($urandom_range(0, 3) == 0);
                eb.decode_fail = 1'($urandom_range(0, 1));
                eb.err_loc     = 8'($urandom_range(16, 203));
                eb.err_val     = 8'($urandom);
            end else begin
                clr_inputs();
            end
            tick();
        end
        chk({name, "_valid_end"}, 32'(out_valid),    32'd0);
        chk({name, "_busy_end"},  32'(busy),         32'd0);
        chk({name, "_ready_end"}, 32'(eb.err_ready), 32'd1);
        exp_bank = ~exp_bank;
    endtask

    task automatic add_err(input logic [7:0] loc, input logic [7:0] val);
        e_loc.push_back(loc);
        e_val.push_back(val);
    endtask

    task automatic clr_errs;
        e_loc.delete();
        e_val.delete();
    endtask

    initial begin
        clr_inputs();
        fill_addr();
        #2 reset = 1'b0;
        tick();
        tick();
        chk_reset_vals("por");
        reset = 1'b1;
        tick();

        // Three back-to-back blocks, banks 1,0,1
        clr_errs();
        run_block("noerr", 1'b0, 1'b0, -1);
        add_err(8'd200, 8'h5A);
        add_err(8'd17,  8'hFF);
        run_block("two_err", 1'b0, 1'b0, -1);
        clr_errs();
        add_err(8'd5,   8'h12);
        add_err(8'd250, 8'h34);
        add_err(8'd100, 8'h33);
        add_err(8'd100, 8'h33);
        run_block("cancel", 1'b1, 1'b0, -1);

        // Uncorrectable blocks
        clr_errs();
        add_err(8'd150, 8'hA5);
        run_block("dfail", 1'b0, 1'b1, -1);
        clr_errs();
        for (int j = 0; j < 9; j++) add_err(8'(20 + j * 10), 8'(j + 1));
        run_block("ovf", 1'b1, 1'b0, -1);
        clr_errs();
        for (int j = 0; j < 8; j++) add_err(8'(30 + j * 7), 8'(8'hC0 + j));
        run_block("full8", 1'b0, 1'b0, -1);

        // Randomized blocks
        for (int b = 0; b < 5; b++) begin
            fill_rand();
            clr_errs();
            for (int j = 0; j < int'($urandom_range(0, 10)); j++) begin
                if ($urandom_range(0, 1) == 1) add_err(8'($urandom_range(16, 30)), 8'($urandom));
                else                           add_err(8'($urandom), 8'($urandom));
            end
            run_block($sformatf("rnd%0d", b), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 7) == 0), -1);
        end

        // Reset at output byte 50, then a clean block from mem0
        fill_addr();
        clr_errs();
        add_err(8'd180, 8'h77);
        run_block("abort", 1'b0, 1'b0, 50);
        clr_errs();
        run_block("after_rst", 1'b0, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
